// File: rtl/dmem_responder_if.sv
// Data-memory request/response handshake between the core memory stage (master)
// and dmem_responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM answering byte/half/word loads and stores with wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN makes misaligned half/word accesses fault.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic            clk,
   input  logic            rst,
   dmem_responder_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        we_q, uns_q;
   logic [31:0] addr_q, wdata_q;
   logic [1:0]  size_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [31:0] mem [DEPTH_WORDS];

   logic          access;
   logic [AW-1:0] widx;
   logic          fault;
   logic [3:0]    lane_en;
   logic [31:0]   lane_data;
   logic [31:0]   word;
   logic [31:0]   load_val;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;

   // Every request spends WAIT_CYCLES+1 cycles in WAIT; the final one is the RAM
   // access cycle, so the response follows acceptance by 1+WAIT_CYCLES edges.
   assign access = (state == WAIT) && (cnt == '0);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.req_valid) state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      widx  = addr_q[AW+1:2];
      word  = mem[widx];
      fault = (size_q == 2'b11) || (addr_q[31:AW+2] != '0);
`ifdef DMEM_MISALIGN_TRAP_EN
      if ((size_q == 2'b01 && addr_q[0]) || (size_q == 2'b10 && addr_q[1:0] != 2'b00))
         fault = 1'b1;
`endif
      lane_en   = '0;
      lane_data = wdata_q;
      case (size_q)
         2'b00: begin
            lane_en   = 4'b0001 << addr_q[1:0];
            lane_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_q[15:0]}};
         end
         2'b10:   lane_en = 4'b1111;
         default: lane_en = '0;
      endcase
      byte_v = word[{addr_q[1:0], 3'b000} +: 8];
      half_v = addr_q[1] ? word[31:16] : word[15:0];
      case (size_q)
         2'b00:   load_val = {{24{~uns_q & byte_v[7]}}, byte_v};
         2'b01:   load_val = {{16{~uns_q & half_v[15]}}, half_v};
         default: load_val = word;
      endcase
      if (we_q || fault)
         load_val = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            size_q  <= bus.req_size;
            wdata_q <= bus.req_wdata;
            cnt     <= 4'(WAIT_CYCLES);
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 4'd1;
         end
         if (access) begin
            rdata_q <= load_val;
            err_q   <= fault;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (access && we_q && !fault)
         for (int unsigned i = 0; i < 4; i++)
            if (lane_en[i])
               mem[widx][8*i +: 8] <= lane_data[8*i +: 8];
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (WAIT_CYCLES=2 and 3) share stimulus,
// selected by sel; expected values are hand-computed constants.
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int          sel = 0;
   logic        v = 1'b0, rr = 1'b0, we_d = 1'b0, uns_d = 1'b0;
   logic [31:0] addr_d = '0, wdata_d = '0;
   logic [1:0]  size_d = '0;
   int          checks = 0, failures = 0;

   dmem_responder_if ifa ();
   dmem_responder_if ifb ();

   assign ifa.req_valid    = v && (sel == 0);
   assign ifb.req_valid    = v && (sel == 1);
   assign ifa.rsp_ready    = rr && (sel == 0);
   assign ifb.rsp_ready    = rr && (sel == 1);
   assign ifa.req_we       = we_d;
   assign ifb.req_we       = we_d;
   assign ifa.req_addr     = addr_d;
   assign ifb.req_addr     = addr_d;
   assign ifa.req_size     = size_d;
   assign ifb.req_size     = size_d;
   assign ifa.req_unsigned = uns_d;
   assign ifb.req_unsigned = uns_d;
   assign ifa.req_wdata    = wdata_d;
   assign ifb.req_wdata    = wdata_d;

   logic        m_req_ready, m_rsp_valid, m_rsp_err;
   logic [31:0] m_rsp_rdata;
   assign m_req_ready = (sel == 1) ? ifb.req_ready : ifa.req_ready;
   assign m_rsp_valid = (sel == 1) ? ifb.rsp_valid : ifa.rsp_valid;
   assign m_rsp_err   = (sel == 1) ? ifb.rsp_err   : ifa.rsp_err;
   assign m_rsp_rdata = (sel == 1) ? ifb.rsp_rdata : ifa.rsp_rdata;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_b (.clk(clk), .rst(rst), .bus(ifb));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xact(input int s, input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
      int n;
      sel = s; we_d = w; addr_d = a; size_d = sz; uns_d = u; wdata_d = d; v = 1'b1;
      n = 0;
      @(negedge clk);
      while (!m_req_ready && n < 50) begin @(negedge clk); n++; end
      check("req_ready_wait", {31'd0, m_req_ready}, 32'd1);
      @(posedge clk); #1 v = 1'b0;
      n = 0;
      @(negedge clk);
      while (!m_rsp_valid && n < 50) begin @(negedge clk); n++; end
      check("rsp_valid_wait", {31'd0, m_rsp_valid}, 32'd1);
      rd = m_rsp_rdata;
      er = m_rsp_err;
      rr = 1'b1;
      @(posedge clk); #1 rr = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_req_ready", {31'd0, ifa.req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd0);
      check("rst_rsp_rdata", ifa.rsp_rdata, 32'd0);
      check("rst_rsp_err",   {31'd0, ifa.rsp_err},   32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Reset during WAIT on the WAIT_CYCLES=3 instance drops the store
      xact(1, 1'b1, 32'h10, 2'b10, 1'b0, 32'h1234_5678, rd, er);
      check("b_store_err", {31'd0, er}, 32'd0);
      xact(1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er);
      check("b_load_pre", rd, 32'h1234_5678);
      sel = 1; we_d = 1'b1; addr_d = 32'h10; size_d = 2'b10; wdata_d = 32'hDEAD_BEEF; v = 1'b1;
      @(posedge clk); #1 v = 1'b0;
      check("b_wait_ready", {31'd0, m_req_ready}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      #1;
      check("b_rst_ready", {31'd0, m_req_ready}, 32'd1);
      check("b_rst_valid", {31'd0, m_rsp_valid}, 32'd0);
      check("b_rst_rdata", m_rsp_rdata, 32'd0);
      check("b_rst_err",   {31'd0, m_rsp_err},   32'd0);
      @(negedge clk); @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      xact(1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er);
      check("b_load_post", rd, 32'h1234_5678);

      // Sign/zero extension
      xact(0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h8000_00F0, rd, er);
      check("st20_rdata", rd, 32'd0);
      check("st20_err", {31'd0, er}, 32'd0);
      xact(0, 1'b0, 32'h20, 2'b00, 1'b0, 32'h0, rd, er);
      check("lb20", rd, 32'hFFFF_FFF0);
      xact(0, 1'b0, 32'h20, 2'b00, 1'b1, 32'h0, rd, er);
      check("lbu20", rd, 32'h0000_00F0);
      xact(0, 1'b0, 32'h22, 2'b01, 1'b0, 32'h0, rd, er);
      check("lh22", rd, 32'hFFFF_8000);
      xact(0, 1'b0, 32'h22, 2'b01, 1'b1, 32'h0, rd, er);
      check("lhu22", rd, 32'h0000_8000);

      // Lane masking
      xact(0, 1'b1, 32'h40, 2'b10, 1'b0, 32'h1122_3344, rd, er);
      xact(0, 1'b1, 32'h41, 2'b00, 1'b0, 32'h5566_77AB, rd, er);
      xact(0, 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, rd, er);
      check("lw40_after_sb", rd, 32'h1122_AB44);
      xact(0, 1'b1, 32'h42, 2'b01, 1'b0, 32'h9999_BEEF, rd, er);
      xact(0, 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, rd, er);
      check("lw40_after_sh", rd, 32'hBEEF_AB44);
      xact(0, 1'b0, 32'h43, 2'b00, 1'b1, 32'h0, rd, er);
      check("lbu43", rd, 32'h0000_00BE);

      // Wait states and back-pressure (WAIT_CYCLES=2)
      sel = 0; we_d = 1'b0; addr_d = 32'h40; size_d = 2'b10; uns_d = 1'b0; v = 1'b1;
      @(posedge clk); #1 v = 1'b0;
      check("stall_ready_n0", {31'd0, m_req_ready}, 32'd0);
      for (int k = 1; k <= 2; k++) begin
         @(posedge clk); #1;
         check("stall_early_valid", {31'd0, m_rsp_valid}, 32'd0);
      end
      @(posedge clk); #1;
      check("stall_valid_n3", {31'd0, m_rsp_valid}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stall_hold_valid", {31'd0, m_rsp_valid}, 32'd1);
         check("stall_hold_rdata", m_rsp_rdata, 32'hBEEF_AB44);
         check("stall_hold_ready", {31'd0, m_req_ready}, 32'd0);
      end
      rr = 1'b1;
      @(posedge clk); #1 rr = 1'b0;
      check("stall_done_ready", {31'd0, m_req_ready}, 32'd1);
      check("stall_done_valid", {31'd0, m_rsp_valid}, 32'd0);

      // Misalignment
      xact(0, 1'b0, 32'h42, 2'b10, 1'b0, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("lw42_err", {31'd0, er}, 32'd1);
      check("lw42_rdata", rd, 32'd0);
`else
      check("lw42_err", {31'd0, er}, 32'd0);
      check("lw42_rdata", rd, 32'hBEEF_AB44);
`endif
      xact(0, 1'b0, 32'h41, 2'b01, 1'b0, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("lh41_err", {31'd0, er}, 32'd1);
      check("lh41_rdata", rd, 32'd0);
`else
      check("lh41_err", {31'd0, er}, 32'd0);
      check("lh41_rdata", rd, 32'hFFFF_AB44);
`endif

      // Range and illegal size
      xact(0, 1'b1, 32'hFFC, 2'b10, 1'b0, 32'hCAFE_F00D, rd, er);
      check("st_last_err", {31'd0, er}, 32'd0);
      xact(0, 1'b0, 32'hFFC, 2'b10, 1'b0, 32'h0, rd, er);
      check("lw_last", rd, 32'hCAFE_F00D);
      xact(0, 1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, rd, er);
      check("lw_oor_err", {31'd0, er}, 32'd1);
      check("lw_oor_rdata", rd, 32'd0);
      xact(0, 1'b1, 32'h40, 2'b11, 1'b0, 32'h0, rd, er);
      check("st_sz3_err", {31'd0, er}, 32'd1);
      xact(0, 1'b1, 32'h1040, 2'b10, 1'b0, 32'h0, rd, er);
      check("st_oor_err", {31'd0, er}, 32'd1);
      xact(0, 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, rd, er);
      check("lw40_unchanged", rd, 32'hBEEF_AB44);
      check("lw40_unchanged_err", {31'd0, er}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
